fifo_push_arb: RTL
==================

FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 Parameter DATA_W, default 8, width of each requester's write data and oWrData.
REQ-002 Parameter MAX_BURST, default 4, maximum consecutive beats per grant (legal range 1..15).
REQ-003 iClk  input  1  single clock; all state updates on rising edge.
REQ-004 iRst  input  1  reset, asynchronous, active-low.
REQ-005 iReq0  input  1  requester 0 has a valid byte on iData0.
REQ-006 iData0  input  DATA_W  requester 0 write data.
REQ-007 oAck0  output  1  requester 0 beat accepted this cycle.
REQ-008 iReq1  input  1  requester 1 has a valid byte on iData1.
REQ-009 iData1  input  DATA_W  requester 1 write data.
REQ-010 oAck1  output  1  requester 1 beat accepted this cycle.
REQ-011 oPush  output  1  push strobe to the FIFO write port.
REQ-012 oWrData  output  DATA_W  data to the FIFO write port.
REQ-013 iFull  input  1  FIFO full flag.
REQ-014 oGrant  output  2  one-hot current owner: bit0 = requester 0, bit1 = requester 1, 00 = idle.

Function
REQ-015 The FSM SHALL have three states: IDLE, G0 and G1; oGrant SHALL be 00, 01 and 10 respectively.
REQ-016 A transfer SHALL occur in Gn exactly when iReqn=1 and iFull=0; oAckn and oPush SHALL be combinational and equal to that condition.
REQ-017 oWrData SHALL equal iData0 in G0, iData1 in G1 and all-zeros in IDLE.
REQ-018 No transfer SHALL occur in IDLE; a grant costs one cycle of latency from IDLE.
REQ-019 From IDLE with exactly one request, the next state SHALL be the grant for that requester.
REQ-020 From IDLE with both requests, the next state SHALL grant the requester that did not own the last grant; after reset, requester 0 wins.
REQ-021 A 4-bit beat counter SHALL clear on every grant entry and increment on each transfer.
REQ-022 Gn SHALL be left when iReqn=0, or when a transfer occurs with count = MAX_BURST-1.
REQ-023 On leaving Gn, the next state SHALL be Gm if the other requester's iReqm=1.
REQ-024 Otherwise, on leaving Gn, the next state SHALL be Gn with the counter cleared if iReqn is still 1 (burst expired, no contender), else IDLE.
REQ-025 iFull=1 SHALL stall in place: state and counter hold, oAck and oPush stay 0, and the grant is not revoked by full.
REQ-026 The last-owner pointer SHALL update on every entry into G0 or G1.
REQ-027 oAck0 and oAck1 SHALL never be 1 in the same cycle; oPush SHALL never be 1 while iFull=1.

Reset
REQ-028 While iRst=0, the block SHALL be in IDLE, with the counter at 0 and the last-owner pointer set to 1 (so requester 0 wins first).
REQ-029 While iRst=0, oGrant, oAck0, oAck1 and oPush SHALL be 0 and oWrData all-zeros.
REQ-030 Reset asserted mid-burst SHALL abort the grant immediately with no further push; after release, arbitration SHALL restart from IDLE.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum (IDLE, G0, G1), the DATA_W default and the counter width constant.
REQ-032 fifo_push_arb SHALL be a single module with no sub-module.
REQ-033 fifo_push_arb SHALL drive the FIFO push/data inputs directly and take iFull from the FIFO full flag.

Verification
REQ-034 Reset, then iReq0=1 with iData0=0x11..0x16 and iFull=0 -> IDLE one cycle, then 6 acks with G0 held (burst re-grant after 4 beats); pushed data 0x11..0x16 in order.
REQ-035 Both requests held, MAX_BURST=4 -> four requester-0 beats, then four requester-1 beats, then four requester-0 beats, with no idle cycle between grants.
REQ-036 In G1 mid-burst, iFull=1 for 3 cycles -> oPush=0 and oAck1=0 for 3 cycles, oGrant=10 held, counter unchanged; the burst resumes when iFull=0.
REQ-037 In G0 after 2 beats, iReq0 drops while iReq1=1 -> next cycle oGrant=10; if iReq1=0 instead -> IDLE.
REQ-038 iRst=0 asserted asynchronously mid-G1 -> outputs go to 0 before the next clock edge; after release with both requests, requester 0 is granted first.
REQ-039 A random bench of at least 10k cycles SHALL check REQ-027 and that per-requester data order into the FIFO is preserved.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// fifo_arb_pkg : shared types and constants for the two-requester FIFO push
//                arbiter.
// Rev 1.0
// ============================================================================
package fifo_arb_pkg;

  localparam int c_DATA_W = 8;
  localparam int c_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_e;

  function automatic logic [1:0] grant_onehot(arb_state_e s);
    case (s)
      G0:      return 2'b01;
      G1:      return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_push_arb.sv
`default_nettype none
// ============================================================================
// fifo_push_arb : round-robin burst arbiter steering two requesters onto one
//                 FIFO write port, with full-flag stalling.
// Rev 1.0
// ============================================================================
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = c_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq0,
  input  logic [DATA_W-1:0] iData0,
  output logic              oAck0,
  input  logic              iReq1,
  input  logic [DATA_W-1:0] iData1,
  output logic              oAck1,
  output logic              oPush,
  output logic [DATA_W-1:0] oWrData,
  input  logic              iFull,
  output logic [1:0]        oGrant
);

  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);

  arb_state_e         state_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic               last_q;

  logic w_own_req;
  logic w_oth_req;
  logic w_xfer;

  assign w_own_req = (state_q == G0) ? iReq0 : (state_q == G1) ? iReq1 : 1'b0;
  assign w_oth_req = (state_q == G0) ? iReq1 : (state_q == G1) ? iReq0 : 1'b0;
  assign w_xfer    = w_own_req & ~iFull;

  assign oAck0  = w_xfer & (state_q == G0);
  assign oAck1  = w_xfer & (state_q == G1);
  assign oPush  = w_xfer;
  assign oGrant = grant_onehot(state_q);

  always_comb begin
    oWrData = '0;
    case (state_q)
      G0:      oWrData = iData0;
      G1:      oWrData = iData1;
      default: oWrData = '0;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // On contention the requester that did not own the last grant wins.
          if (iReq0 && (!iReq1 || last_q)) begin
            state_q <= G0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (iReq1) begin
            state_q <= G1;
            last_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        G0, G1: begin
          // A full FIFO freezes the grant: no state or count movement at all.
          if (!iFull) begin
            if (!w_own_req || (cnt_q == c_LAST_BEAT)) begin
              cnt_q <= '0;
              if (w_oth_req) begin
                state_q <= (state_q == G0) ? G1 : G0;
                last_q  <= (state_q == G0);
              end else if (!w_own_req) begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
